// File: rtl/alu_seq.sv
// Sequential ALU with accumulator file: single-cycle arithmetic/logic ops,
// bit-serial shifts and a shift-add multiplier, with maskable Z/N/H/C flags.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int NACC  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [3:0]              op,
    input  logic [WIDTH-1:0]        x,
    input  logic [WIDTH-1:0]        y,
    input  logic                    write_acc,
    input  logic [$clog2(NACC)-1:0] dst,
    input  logic [3:0]              flag_mask,
    input  logic [$clog2(NACC)-1:0] rd_sel,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    ready,
    output logic                    done,
    output logic [WIDTH-1:0]        result,
    output logic [7:0]              flags
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam int AW = $clog2(NACC);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state, state_nx;

    logic [NACC-1:0][WIDTH-1:0] acc;
    logic [3:0]         flag_r;          // {Z,N,H,C}
    logic [3:0]         op_r, mask_r;
    logic               wr_r;
    logic [AW-1:0]      dst_r;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   work;            // shift operand, or multiplicand for MUL
    logic [2*WIDTH-1:0] prod;            // {partial high, remaining multiplier}
    logic               sc;

    // single-cycle datapath on the live inputs
    logic               cin;
    logic [WIDTH:0]     ext;
    logic [4:0]         nib;
    logic [WIDTH-1:0]   a_res;
    logic [3:0]         a_f;
    logic               a_pass;

    // one iteration step for shifts / multiply
    logic [WIDTH-1:0]   work_nx, i_res;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH:0]     madd;
    logic               sc_nx, i_c;

    // commit bundle for the edge entering DONE
    logic               load, commit, c_pass, c_wr;
    logic [WIDTH-1:0]   c_res;
    logic [3:0]         c_f, c_mask;
    logic [AW-1:0]      c_dst;

    assign ready   = (state == IDLE);
    assign done    = (state == DONE);
    assign flags   = {flag_r, 4'b0000};
    assign rd_data = acc[rd_sel];

    always_comb begin
        cin    = 1'b0;
        ext    = '0;
        nib    = '0;
        a_res  = x;
        a_f    = 4'b0000;
        a_pass = 1'b0;
        case (op)
            4'd0, 4'd8: begin
                cin    = (op == 4'd8) & flag_r[0];
                ext    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
                nib    = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0000, cin};
                a_res  = ext[WIDTH-1:0];
                a_f[0] = ext[WIDTH];
                a_f[1] = nib[4];
            end
            4'd1, 4'd9: begin
                cin    = (op == 4'd9) & flag_r[0];
                ext    = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin};
                nib    = {1'b0, x[3:0]} - {1'b0, y[3:0]} - {4'b0000, cin};
                a_res  = ext[WIDTH-1:0];
                a_f[0] = ext[WIDTH];
                a_f[1] = nib[4];
                a_f[2] = 1'b1;
            end
            4'd2: begin
                a_res  = x & y;
                a_f[1] = 1'b1;
            end
            4'd3: a_res = x | y;
            4'd4: a_res = x ^ y;
            4'd5, 4'd6, 4'd7: a_res = x;   // zero-count shift lands here
            default: a_pass = 1'b1;
        endcase
        a_f[3] = (a_res == '0);
    end

    always_comb begin
        work_nx = work;
        prod_nx = prod;
        sc_nx   = sc;
        madd    = '0;
        case (op_r)
            4'd5: begin
                work_nx = {work[WIDTH-2:0], 1'b0};
                sc_nx   = work[WIDTH-1];
            end
            4'd6: begin
                work_nx = {1'b0, work[WIDTH-1:1]};
                sc_nx   = work[0];
            end
            4'd7: begin
                madd    = {1'b0, prod[2*WIDTH-1:WIDTH]}
                        + (prod[0] ? {1'b0, work} : {(WIDTH+1){1'b0}});
                prod_nx = {madd, prod[WIDTH-1:1]};
            end
            default: ;
        endcase
        i_res = (op_r == 4'd7) ? prod_nx[WIDTH-1:0] : work_nx;
        i_c   = (op_r == 4'd7) ? |prod_nx[2*WIDTH-1:WIDTH] : sc_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        commit   = 1'b0;
        c_res    = a_res;
        c_f      = a_f;
        c_pass   = a_pass;
        c_mask   = flag_mask;
        c_wr     = write_acc;
        c_dst    = dst;
        case (state)
            IDLE: if (start) begin
                if (op == 4'd7 || ((op == 4'd5 || op == 4'd6) && y[SW-1:0] != '0)) begin
                    load     = 1'b1;
                    state_nx = ITER;
                end else begin
                    commit   = 1'b1;
                    state_nx = DONE;
                end
            end
            ITER: if (cnt == CW'(1)) begin
                commit   = 1'b1;
                c_res    = i_res;
                c_f      = {i_res == '0, 1'b0, 1'b0, i_c};
                c_pass   = 1'b0;
                c_mask   = mask_r;
                c_wr     = wr_r;
                c_dst    = dst_r;
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            result <= '0;
            flag_r <= 4'b0000;
            acc    <= '0;
            op_r   <= '0;
            mask_r <= '0;
            wr_r   <= 1'b0;
            dst_r  <= '0;
            cnt    <= '0;
            work   <= '0;
            prod   <= '0;
            sc     <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                op_r   <= op;
                mask_r <= flag_mask;
                wr_r   <= write_acc;
                dst_r  <= dst;
                work   <= x;
                prod   <= {{WIDTH{1'b0}}, y};
                sc     <= 1'b0;
                cnt    <= (op == 4'd7) ? CW'(WIDTH) : {1'b0, y[SW-1:0]};
            end else if (state == ITER) begin
                work <= work_nx;
                prod <= prod_nx;
                sc   <= sc_nx;
                cnt  <= cnt - CW'(1);
            end
            if (commit) begin
                result <= c_res;
                if (!c_pass)
                    for (int i = 0; i < 4; i++)
                        if (c_mask[i]) flag_r[i] <= c_f[i];
                if (c_wr) acc[c_dst] <= c_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, busy/reset corner sequences and
// random ops checked against an arithmetic reference model.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset, start, write_acc;
    logic [3:0]  op, flag_mask;
    logic [15:0] x, y, rd_data, result;
    logic [1:0]  dst, rd_sel;
    logic        ready, done;
    logic [7:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0]  m_fl;          // {Z,N,H,C}
    logic [15:0] m_acc [4];

    alu_seq #(.WIDTH(16), .NACC(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y),
        .write_acc(write_acc), .dst(dst), .flag_mask(flag_mask), .rd_sel(rd_sel),
        .rd_data(rd_data), .ready(ready), .done(done), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] x, y;
        bit          wr;
        logic [1:0]  dst;
        logic [3:0]  mask;
        logic [15:0] res;
        logic [7:0]  fl;
        int          lat;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, output logic [15:0] r, output logic [3:0] f,
                                  output bit p, output int lat);
        longint la, lb, s, cv;
        int n;
        la = a; lb = b; n = int'(b & 16'h000F);
        cv = ((o == 4'd8 || o == 4'd9) && cin) ? 1 : 0;
        p = 0; lat = 1; f = 4'b0000; r = a;
        case (o)
            4'd0, 4'd8: begin
                s = la + lb + cv; r = 16'(s);
                f[0] = (s > 65535);
                f[1] = ((la % 16) + (lb % 16) + cv) > 15;
            end
            4'd1, 4'd9: begin
                s = la - lb - cv; r = 16'(s);
                f[0] = (s < 0);
                f[1] = ((la % 16) - (lb % 16) - cv) < 0;
                f[2] = 1'b1;
            end
            4'd2: begin r = a & b; f[1] = 1'b1; end
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin
                r = 16'(la << n);
                f[0] = (n != 0) ? (((la >> (16 - n)) & 1) != 0) : 1'b0;
                lat = 1 + n;
            end
            4'd6: begin
                r = 16'(la >> n);
                f[0] = (n != 0) ? (((la >> (n - 1)) & 1) != 0) : 1'b0;
                lat = 1 + n;
            end
            4'd7: begin
                s = la * lb; r = 16'(s);
                f[0] = ((s >> 16) != 0);
                lat = 17;
            end
            default: p = 1;
        endcase
        f[3] = (r == 16'h0000);
    endfunction

    // Caller sits just after a negedge; returns just after the cycle following done.
    task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                          input bit wr, input logic [1:0] d, input logic [3:0] m, input bit poke,
                          output logic [15:0] r, output logic [7:0] fl, output int cyc);
        int w, el, idx;
        logic [15:0] er;
        logic [3:0]  ef;
        bit          ep;
        w = 0;
        while (!ready && w < 40) begin @(negedge clk); w++; end
        if (!ready) check("ready_wait", 0, 1);
        model(o, a, b, m_fl[0], er, ef, ep, el);
        start = 1; op = o; x = a; y = b; write_acc = wr; dst = d; flag_mask = m;
        @(posedge clk);
        #1;
        start = 0; op = 4'($urandom); x = 16'($urandom); y = 16'($urandom);
        write_acc = 1'($urandom); dst = 2'($urandom); flag_mask = 4'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) begin start = 1; op = 4'd0; x = 16'h0001; y = 16'h0001; end
            if (poke && cyc == 3) check("busy_ready", 32'(ready), 0);
            if (poke && cyc == 4) start = 0;
        end while (!done && cyc < 40);
        check("latency", cyc, el);
        check("result", result, er);
        if (!ep)
            for (int i = 0; i < 4; i++) if (m[i]) m_fl[i] = ef[i];
        if (wr) m_acc[d] = er;
        check("flags", flags, {m_fl, 4'b0000});
        idx = $urandom_range(0, 3);
        rd_sel = 2'(idx);
        #1;
        check("rd_data", rd_data, m_acc[idx]);
        r = result; fl = flags;
        @(negedge clk);
        check("done_pulse", {done, ready}, 2'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r;
        logic [7:0]  fl;
        int          cyc, cnt;

        tbl[0]  = '{4'd0,  16'hFFFF, 16'h0001, 0, 2'd0, 4'hF, 16'h0000, 8'hB0, 1};
        tbl[1]  = '{4'd1,  16'h0010, 16'h0001, 1, 2'd3, 4'hF, 16'h000F, 8'h60, 1};
        tbl[2]  = '{4'd9,  16'h0010, 16'h0001, 0, 2'd0, 4'hF, 16'h000F, 8'h60, 1};
        tbl[3]  = '{4'd7,  16'h0100, 16'h0100, 1, 2'd2, 4'hF, 16'h0000, 8'h90, 17};
        tbl[4]  = '{4'd7,  16'h0003, 16'h0005, 0, 2'd0, 4'hF, 16'h000F, 8'h00, 17};
        tbl[5]  = '{4'd5,  16'h8001, 16'h0001, 0, 2'd0, 4'hF, 16'h0002, 8'h10, 2};
        tbl[6]  = '{4'd5,  16'h8001, 16'h0000, 0, 2'd0, 4'hF, 16'h8001, 8'h00, 1};
        tbl[7]  = '{4'd0,  16'hFFFF, 16'h0001, 0, 2'd0, 4'hF, 16'h0000, 8'hB0, 1};
        tbl[8]  = '{4'd1,  16'h0000, 16'h0001, 0, 2'd0, 4'h4, 16'hFFFF, 8'hF0, 1};
        tbl[9]  = '{4'd0,  16'h0001, 16'h0001, 0, 2'd0, 4'h1, 16'h0002, 8'hE0, 1};
        tbl[10] = '{4'd10, 16'h1234, 16'h0000, 0, 2'd0, 4'hF, 16'h1234, 8'hE0, 1};
        tbl[11] = '{4'd6,  16'h800F, 16'h00F4, 0, 2'd0, 4'hF, 16'h0800, 8'h10, 5};
        tbl[12] = '{4'd8,  16'h0007, 16'h0008, 0, 2'd0, 4'hF, 16'h0010, 8'h20, 1};
        tbl[13] = '{4'd2,  16'hF0F0, 16'h0F0F, 0, 2'd0, 4'hF, 16'h0000, 8'hA0, 1};
        tbl[14] = '{4'd4,  16'h1234, 16'h00FF, 1, 2'd1, 4'hF, 16'h12CB, 8'h00, 1};

        reset = 1; start = 0; op = 0; x = 0; y = 0; write_acc = 0; dst = 0;
        flag_mask = 0; rd_sel = 0;
        m_fl = 4'b0000;
        for (int i = 0; i < 4; i++) m_acc[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1 check("rst_acc", rd_data, 0);
        end

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].wr, tbl[i].dst, tbl[i].mask, 0, r, fl, cyc);
            check($sformatf("vec%0d_res", i), r, tbl[i].res);
            check($sformatf("vec%0d_flags", i), fl, tbl[i].fl);
            check($sformatf("vec%0d_lat", i), cyc, tbl[i].lat);
        end

        // start held during a multiply must not be queued behind it
        run_op(4'd7, 16'h0003, 16'h0005, 0, 2'd0, 4'hF, 1, r, fl, cyc);
        check("busy_mul_res", r, 16'h000F);
        cnt = 0;
        repeat (6) begin @(negedge clk); if (done) cnt++; end
        check("busy_no_queue", cnt, 0);

        // reset in the middle of a multiply with accumulator write pending
        start = 1; op = 4'd7; x = 16'h1234; y = 16'h0055; write_acc = 1; dst = 2'd1; flag_mask = 4'hF;
        @(posedge clk);
        #1 start = 0;
        repeat (5) @(negedge clk);
        check("mid_busy", 32'(ready), 0);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 1);
        check("abort_done", 32'(done), 0);
        check("abort_flags", flags, 0);
        check("abort_result", result, 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1 check("abort_acc", rd_data, 0);
        end
        cnt = 0;
        repeat (20) begin @(negedge clk); if (done) cnt++; end
        check("abort_no_done", cnt, 0);
        m_fl = 4'b0000;
        for (int i = 0; i < 4; i++) m_acc[i] = 16'h0000;

        for (int i = 0; i < 60; i++)
            run_op(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                   2'($urandom), 4'($urandom), 0, r, fl, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, 16, operand, result and accumulator width (8..32).
REQ-002 Parameter NACC, 4, number of accumulator registers (power of two, >=2).
REQ-003 Port clk  in  1  clock; all state updates on posedge.
REQ-004 Port reset  in  1  reset, synchronous, active-high.
REQ-005 Port start  in  1  request; accepted only on an edge where ready=1.
REQ-006 Port op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL, 8 ADC, 9 SBC, 10-15 PASS.
REQ-007 Port x, y  in  WIDTH each  operands.
REQ-008 Port write_acc  in  1  write result to accumulator dst on completion.
REQ-009 Port dst  in  log2(NACC)  destination accumulator index.
REQ-010 Port flag_mask  in  4  per-flag update enable {Z,N,H,C}.
REQ-011 Port rd_sel  in  log2(NACC)  accumulator read index.
REQ-012 Port rd_data  out  WIDTH  acc[rd_sel], combinational.
REQ-013 Port ready  out  1  high only in IDLE.
REQ-014 Port done  out  1  one-cycle completion pulse.
REQ-015 Port result  out  WIDTH  registered result of last completed op.
REQ-016 Port flags  out  8  {Z,N,H,C,4'b0000}, registered.

Function
REQ-017 States IDLE, ITER, DONE; ready=(IDLE), done=(DONE).
REQ-018 Accept edge: op, x, y, write_acc, dst, flag_mask, and current C latched; later input changes ignored until next accept.
REQ-019 start while ready=0 ignored, no queuing.
REQ-020 ADD/SUB/AND/OR/XOR/ADC/SBC/PASS: IDLE->DONE on accept edge k; done=1 and result valid in cycle k+1.
REQ-021 SHL/SHR: shift count n = y[log2(WIDTH)-1:0]; n=0 -> IDLE->DONE; else IDLE->ITER, one bit per cycle, n ITER cycles, done in cycle k+1+n.
REQ-022 MUL: shift-add, exactly WIDTH ITER cycles, done in cycle k+1+WIDTH; result = low WIDTH bits of x*y.
REQ-023 DONE always -> IDLE next edge; back-to-back single-cycle ops therefore every 2 cycles.
REQ-024 ADC/SBC use latched C as carry/borrow in; ADD/SUB use 0.
REQ-025 Z = (result==0) for all ops.
REQ-026 N = 1 for SUB/SBC, 0 otherwise.
REQ-027 H = carry (ADD/ADC) or borrow (SUB/SBC) out of bit 3; 1 for AND; 0 otherwise.
REQ-028 C = carry out of MSB (ADD/ADC), borrow (SUB/SBC), last bit shifted out (SHL/SHR, 0 if n=0), OR of product bits above WIDTH-1 (MUL), 0 for logic ops.
REQ-029 PASS: result=x, flags unchanged regardless of flag_mask.
REQ-030 result and masked flags update on the edge entering DONE; flag bits with mask=0 retain value.
REQ-031 write_acc=1: acc[dst]<=result on same edge; write_acc=0: accumulators unchanged.
REQ-032 rd_data reflects accumulator write from cycle after the write edge.

Reset
REQ-033 reset=1 at an edge: state IDLE, result=0, flags=0x00, all accumulators=0, done=0, ready=1 in following cycle.
REQ-034 reset overrides start and aborts ITER mid-operation; partial results discarded, no accumulator write.

Verification (WIDTH=16, NACC=4)
REQ-035 ADD x=0xFFFF y=0x0001 mask=0xF -> done at k+1, result 0x0000, flags 0xB0.
REQ-036 SUB x=0x0010 y=0x0001 mask=0xF -> result 0x000F, flags 0x60; then SBC x=0x0010 y=0x0001 with C=0 -> same.
REQ-037 MUL x=0x0100 y=0x0100 write_acc=1 dst=2 -> ready low 17 cycles, done at k+17, result 0x0000, flags 0x90, acc[2]=0x0000; x=3 y=5 -> 0x000F, flags 0x00.
REQ-038 SHL x=0x8001 y=1 -> done k+2, result 0x0002, flags 0x10; y=0 -> done k+1, result 0x8001, C=0.
REQ-039 Flags 0xF0, ADD x=1 y=1 mask=0x1 -> flags 0xE0, result 0x0002; PASS x=0x1234 -> result 0x1234, flags 0xE0.
REQ-040 reset during MUL ITER cycle 5 with write_acc=1 -> next cycle ready=1, done=0, flags 0x00, all acc 0, no done pulse; start during ITER -> ignored.
